// File: rtl/stream_mux_pkg.sv
// Shared types for the packet-aware round-robin stream mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_mux_pkg;

    // IDLE: free to arbitrate; LOCKk: mid-packet on source k, no switching.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Width of the source index carried alongside each beat.
    localparam int SRC_W = 1;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry registered output stage for a valid/ready stream.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds payload stable while out_valid & ~out_ready; can_load drops.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   load         accept load_pay into the register this cycle
//   load_pay     payload to register
//   out_ready    downstream accept
//   out_valid    registered beat valid
//   out_pay      registered payload
//   can_load     register is empty or being drained this cycle
module stream_out_reg #(
    parameter int PW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [PW-1:0] load_pay,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_pay,
    output logic          can_load
);

    assign can_load = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pay   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pay   <= load_pay;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_stream_mux2.sv
// Packet-aware round-robin 2:1 stream mux; packets are never interleaved.
// Latency: 1 cycle input accept -> out_valid; 1 beat/cycle with out_ready held high.
// Backpressure: out_valid & ~out_ready freezes the output and drops both in*_ready.
//
// Ports:
//   clk, rst_n                       clock and async active-low reset
//   inK_valid/ready/data/last        source K stream (K = 0, 1)
//   out_valid/ready/data/last        registered output stream
//   out_src                          source index of the registered beat
module rr_stream_mux2
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [SRC_W-1:0] out_src
);

    localparam int PW = WIDTH + 1 + SRC_W;

    arb_state_t       state, state_nxt;
    logic [SRC_W-1:0] rr_ptr, rr_nxt;      // source served most recently

    logic             grant_en;
    logic [SRC_W-1:0] grant_src;
    logic             can_load;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             accept;
    logic [PW-1:0]    load_pay;
    logic [PW-1:0]    out_pay;

    // Grant selection. Gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        grant_en  = 1'b0;
        grant_src = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (in0_valid && in1_valid) begin
                        grant_en  = 1'b1;
                        grant_src = ~rr_ptr;
                    end else if (in0_valid) begin
                        grant_en  = 1'b1;
                        grant_src = 1'b0;
                    end else if (in1_valid) begin
                        grant_en  = 1'b1;
                        grant_src = 1'b1;
                    end
                end
                // Locked: keep the grant even with a bubble so the other
                // source can never slip in mid-packet.
                LOCK0: begin
                    grant_en  = 1'b1;
                    grant_src = 1'b0;
                end
                LOCK1: begin
                    grant_en  = 1'b1;
                    grant_src = 1'b1;
                end
                default: begin
                    grant_en  = 1'b0;
                    grant_src = '0;
                end
            endcase
        end
    end

    // 2:1 mux driven by the grant.
    assign sel_valid = (grant_src == 1'b1) ? in1_valid : in0_valid;
    assign sel_last  = (grant_src == 1'b1) ? in1_last  : in0_last;
    assign sel_data  = (grant_src == 1'b1) ? in1_data  : in0_data;

    assign in0_ready = grant_en & (grant_src == 1'b0) & can_load;
    assign in1_ready = grant_en & (grant_src == 1'b1) & can_load;
    assign accept    = grant_en & can_load & sel_valid;

    assign load_pay  = {grant_src, sel_last, sel_data};

    // Next state: a last beat returns to IDLE and records the source for
    // round-robin; a non-last beat locks onto its source.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        if (!(state inside {IDLE, LOCK0, LOCK1})) begin
            state_nxt = IDLE;
        end else if (accept) begin
            if (sel_last) begin
                state_nxt = IDLE;
                rr_nxt    = grant_src;
            end else begin
                state_nxt = (grant_src == 1'b1) ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;    // src0 wins the first tie
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    stream_out_reg #(
        .PW (PW)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_pay  (load_pay),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pay   (out_pay),
        .can_load  (can_load)
    );

    assign out_src  = out_pay[PW-1 -: SRC_W];
    assign out_last = out_pay[WIDTH];
    assign out_data = out_pay[WIDTH-1:0];

endmodule
